// File: rtl/video_pkg.sv
// Shared timing constants, rectangle table geometry and copy FSM encoding
// for the 640x480@60 scan controller.
package video_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int RECT_WORDS = 6;
    localparam int RECT_COUNT = 64;
    localparam int TABLE_LEN  = RECT_COUNT * RECT_WORDS;

    localparam logic [15:0] TABLE_BASE = 16'd0;
    localparam int          GPU_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } copy_state_t;

endpackage

// File: rtl/video_scan_if.sv
// Bundle of raster, video-RAM, gpu and display signals around video_scan.
// master is the scan controller; slave is the RAM/gpu/display side.
interface video_scan_if;

    logic [15:0] x_coord;
    logic [15:0] y_coord;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        gpu_we;
    logic [15:0] gpu_din;
    logic        gpu_idle;
    logic [15:0] gpu_color;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] rgb;
    logic        frame_irq;

    modport master (
        output x_coord, y_coord, mem_addr, gpu_we, gpu_din, gpu_idle,
               hsync, vsync, de, rgb, frame_irq,
        input  mem_rdata, gpu_color
    );

    modport slave (
        input  x_coord, y_coord, mem_addr, gpu_we, gpu_din, gpu_idle,
               hsync, vsync, de, rgb, frame_irq,
        output mem_rdata, gpu_color
    );

endinterface

// File: rtl/sync_delay.sv
// Parameterised shift register with a programmable reset value; a depth of
// zero degenerates to a wire.
module sync_delay #(
    parameter int               DEPTH     = 1,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] stage_in;
                logic [WIDTH-1:0] q_reg;

                if (gi == 0) begin : g_first
                    assign stage_in = din;
                end else begin : g_rest
                    assign stage_in = g_stage[gi-1].q_reg;
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) q_reg <= RESET_VAL;
                    else     q_reg <= stage_in;
                end
            end
            assign dout = g_stage[DEPTH-1].q_reg;
        end
    endgenerate

endmodule

// File: rtl/video_scan.sv
// Pixel-rate raster generator that also reloads the gpu rectangle table from
// video RAM once per frame and aligns sync/blanking with the gpu colour.
module video_scan #(
    parameter int          H_ACTIVE    = video_pkg::H_ACTIVE,
    parameter int          H_FP        = video_pkg::H_FP,
    parameter int          H_SYNC      = video_pkg::H_SYNC,
    parameter int          H_BP        = video_pkg::H_BP,
    parameter int          V_ACTIVE    = video_pkg::V_ACTIVE,
    parameter int          V_FP        = video_pkg::V_FP,
    parameter int          V_SYNC      = video_pkg::V_SYNC,
    parameter int          V_BP        = video_pkg::V_BP,
    parameter logic [15:0] TABLE_BASE  = video_pkg::TABLE_BASE,
    parameter int          TABLE_LEN   = video_pkg::TABLE_LEN,
    parameter int          GPU_LATENCY = video_pkg::GPU_LATENCY
) (
    input  logic         pixel_clk,
    input  logic         reset,
    video_scan_if.master bus
);

    import video_pkg::*;

    // The copy must fit inside one blank line (TABLE_LEN + 2 <= line total).
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int IDX_W   = ($clog2(TABLE_LEN + 1) > 9) ? $clog2(TABLE_LEN + 1) : 9;

    localparam logic [15:0]      H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0]      V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0]      H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0]      V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0]      HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0]      HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0]      VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0]      VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TABLE_LEN - 1);

    logic [15:0]      x_reg, y_reg, x_next, y_next;
    copy_state_t      state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             drain_reg;
    logic [15:0]      mem_addr_reg;
    logic             rd_valid_reg, gpu_we_reg, frame_irq_reg, gpu_idle_reg;
    logic [15:0]      gpu_din_reg;
    logic             hsync_reg, vsync_reg, de_reg;
    logic [15:0]      rgb_reg;
    logic             copy_start, rd_issue, copy_busy;
    logic             hs_raw, vs_raw, de_raw;
    logic [2:0]       sync_d;

    always_comb begin
        x_next = (x_reg == H_LAST) ? 16'd0 : x_reg + 16'd1;
        y_next = y_reg;
        if (x_reg == H_LAST) y_next = (y_reg == V_LAST) ? 16'd0 : y_reg + 16'd1;
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            x_reg <= 16'd0;
            y_reg <= 16'd0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    // Word 0 is already on mem_addr (TABLE_BASE) in the start cycle, so the
    // READ state walks words 1..TABLE_LEN-1.
    assign copy_start = (state_reg == IDLE) && (x_reg == 16'd0) && (y_reg == V_ACT);
    assign rd_issue   = copy_start || (state_reg == READ);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            drain_reg    <= 1'b0;
            mem_addr_reg <= TABLE_BASE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (copy_start) begin
                        state_reg    <= READ;
                        idx_reg      <= IDX_W'(1);
                        mem_addr_reg <= TABLE_BASE + 16'd1;
                    end
                end
                READ: begin
                    if (idx_reg == IDX_LAST) begin
                        state_reg    <= DRAIN;
                        idx_reg      <= '0;
                        drain_reg    <= 1'b0;
                        mem_addr_reg <= TABLE_BASE;
                    end else begin
                        idx_reg      <= idx_reg + IDX_W'(1);
                        mem_addr_reg <= TABLE_BASE + 16'(idx_reg) + 16'd1;
                    end
                end
                DRAIN: begin
                    drain_reg <= 1'b1;
                    if (drain_reg) begin
                        state_reg <= IDLE;
                        drain_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Idle only once the whole copy, including the irq cycle, has retired.
    assign copy_busy = rd_issue || (state_reg != IDLE) || rd_valid_reg ||
                       gpu_we_reg || frame_irq_reg;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            rd_valid_reg  <= 1'b0;
            gpu_we_reg    <= 1'b0;
            gpu_din_reg   <= 16'd0;
            frame_irq_reg <= 1'b0;
            gpu_idle_reg  <= 1'b0;
        end else begin
            rd_valid_reg  <= rd_issue;
            gpu_we_reg    <= rd_valid_reg;
            if (rd_valid_reg) gpu_din_reg <= bus.mem_rdata;
            frame_irq_reg <= gpu_we_reg && !rd_valid_reg;
            gpu_idle_reg  <= (y_next >= V_ACT) &&
                             !((x_next == 16'd0) && (y_next == V_ACT)) && !copy_busy;
        end
    end

    assign hs_raw = !((x_reg >= HS_START) && (x_reg < HS_END));
    assign vs_raw = !((y_reg >= VS_START) && (y_reg < VS_END));
    assign de_raw = (x_reg < H_ACT) && (y_reg < V_ACT);

    sync_delay #(
        .DEPTH     (GPU_LATENCY),
        .WIDTH     (3),
        .RESET_VAL (3'b110)
    ) u_sync_delay (
        .clk  (pixel_clk),
        .rst  (reset),
        .din  ({hs_raw, vs_raw, de_raw}),
        .dout (sync_d)
    );

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            de_reg    <= 1'b0;
            rgb_reg   <= 16'd0;
        end else begin
            hsync_reg <= sync_d[2];
            vsync_reg <= sync_d[1];
            de_reg    <= sync_d[0];
            rgb_reg   <= sync_d[0] ? bus.gpu_color : 16'd0;
        end
    end

    assign bus.x_coord   = x_reg;
    assign bus.y_coord   = y_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.gpu_we    = gpu_we_reg;
    assign bus.gpu_din   = gpu_din_reg;
    assign bus.gpu_idle  = gpu_idle_reg;
    assign bus.frame_irq = frame_irq_reg;
    assign bus.hsync     = hsync_reg;
    assign bus.vsync     = vsync_reg;
    assign bus.de        = de_reg;
    assign bus.rgb       = rgb_reg;

endmodule

// File: tb/tb_video_scan.sv
// Scoreboard bench for video_scan with a shortened vertical raster so several
// frames, table copies and resets fit in a short run.
module tb_video_scan;

    localparam int HA = 640, HT = 800, HSS = 656, HSE = 752;
    localparam int VA = 6, VFP = 2, VSY = 2, VBP = 2;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int VSS = VA + VFP, VSE = VA + VFP + VSY;
    localparam int LEN = 384;

    typedef struct {
        int          t;
        logic [15:0] x, y, addr, rgb;
        logic        hs, vs, de, we, irq, idle;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    video_scan_if vif();

    video_scan #(
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSY),
        .V_BP     (VBP)
    ) dut (
        .pixel_clk (clk),
        .reset     (rst),
        .bus       (vif)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [15:0] din_q[$];
    logic [15:0] ram [512];
    int          t, mon_t, checks, errors;
    logic        in_reset, blank_mode;
    logic [15:0] color_cur, color_prev;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s t=%0d actual %h expected %h", name, mon_t, act, want);
        end
    endtask

    function automatic logic raw_de(input int tt);
        return ((tt % HT) < HA) && (((tt / HT) % VT) < VA);
    endfunction

    function automatic logic raw_hs(input int tt);
        return !(((tt % HT) >= HSS) && ((tt % HT) < HSE));
    endfunction

    function automatic logic raw_vs(input int tt);
        int yy;
        yy = (tt / HT) % VT;
        return !((yy >= VSS) && (yy < VSE));
    endfunction

    // Drive this cycle's gpu colour and queue what the outputs must show now.
    task automatic drive_push();
        exp_t e;
        int   xx, yy;
        color_prev = color_cur;
        color_cur  = blank_mode ? 16'hFFFF : 16'($urandom);
        vif.gpu_color = color_cur;
        xx = t % HT;
        yy = (t / HT) % VT;
        e.t    = t;
        e.x    = 16'(xx);
        e.y    = 16'(yy);
        e.addr = (yy == VA && xx < LEN) ? 16'(xx) : 16'd0;
        e.we   = (yy == VA) && (xx >= 2) && (xx <= LEN + 1);
        e.irq  = (yy == VA) && (xx == LEN + 2);
        e.idle = (yy >= VA) && !((yy == VA) && (xx < LEN + 4));
        if (t >= 2) begin
            e.hs  = raw_hs(t - 2);
            e.vs  = raw_vs(t - 2);
            e.de  = raw_de(t - 2);
            e.rgb = e.de ? color_prev : 16'd0;
        end else begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.de  = 1'b0;
            e.rgb = 16'd0;
        end
        if (yy == VA && xx == 0)
            for (int k = 0; k < LEN; k++) din_q.push_back(ram[k]);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
        drive_push();
    endtask

    task automatic run_until(input int target);
        while (t < target) step();
    endtask

    task automatic release_reset();
        rst      = 1'b0;
        in_reset = 1'b0;
        exp_q.delete();
        din_q.delete();
        t = 0;
        drive_push();
    endtask

    // Called at posedge+1: reset takes effect mid-cycle and is held n edges.
    task automatic hit_reset(input int n);
        rst      = 1'b1;
        in_reset = 1'b1;
        exp_q.delete();
        din_q.delete();
        repeat (n) @(posedge clk);
        #1;
        release_reset();
    endtask

    // Synchronous video-RAM model, one cycle of read latency.
    initial begin
        int lat;
        vif.mem_rdata = 16'd0;
        forever begin
            @(negedge clk);
            lat = int'(vif.mem_addr[8:0]);
            @(posedge clk);
            #1;
            vif.mem_rdata = ram[lat];
        end
    end

    // Monitor: one expected entry per cycle, plus the copy stream on gpu_we.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                mon_t = -1;
                chk("rst_x", vif.x_coord, 16'd0);
                chk("rst_y", vif.y_coord, 16'd0);
                chk("rst_addr", vif.mem_addr, 16'd0);
                chk("rst_we", 16'(vif.gpu_we), 16'd0);
                chk("rst_din", vif.gpu_din, 16'd0);
                chk("rst_idle", 16'(vif.gpu_idle), 16'd0);
                chk("rst_irq", 16'(vif.frame_irq), 16'd0);
                chk("rst_hsync", 16'(vif.hsync), 16'd1);
                chk("rst_vsync", 16'(vif.vsync), 16'd1);
                chk("rst_de", 16'(vif.de), 16'd0);
                chk("rst_rgb", vif.rgb, 16'd0);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty t=%0d actual none expected entry", t);
            end else begin
                e = exp_q.pop_front();
                mon_t = e.t;
                chk("x_coord", vif.x_coord, e.x);
                chk("y_coord", vif.y_coord, e.y);
                chk("mem_addr", vif.mem_addr, e.addr);
                chk("gpu_we", 16'(vif.gpu_we), 16'(e.we));
                chk("frame_irq", 16'(vif.frame_irq), 16'(e.irq));
                chk("gpu_idle", 16'(vif.gpu_idle), 16'(e.idle));
                chk("hsync", 16'(vif.hsync), 16'(e.hs));
                chk("vsync", 16'(vif.vsync), 16'(e.vs));
                chk("de", 16'(vif.de), 16'(e.de));
                chk("rgb", vif.rgb, e.rgb);
                if (vif.gpu_we === 1'b1) begin
                    if (din_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL gpu_din_extra t=%0d actual %h expected no write", e.t, vif.gpu_din);
                    end else begin
                        chk("gpu_din", vif.gpu_din, din_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        t          = 0;
        mon_t      = 0;
        blank_mode = 1'b0;
        color_cur  = 16'd0;
        color_prev = 16'd0;
        rst        = 1'b1;
        in_reset   = 1'b1;
        vif.gpu_color = 16'd0;
        for (int k = 0; k < 512; k++) ram[k] = 16'hA000 + 16'(k);

        repeat (3) @(posedge clk);
        #1;
        release_reset();

        // Random-length run, then a reset in the middle of a line.
        run_until(int'($urandom_range(700, 200)));
        hit_reset(2);

        // Abort the first copy while word 100 is being addressed.
        run_until(VA * HT + 100);
        hit_reset(3);

        // First complete copy (A000..A17F), then reload the table at random.
        run_until(VA * HT + LEN + 20);
        for (int k = 0; k < LEN; k++) ram[k] = 16'($urandom);

        // Constant white from the gpu across a frame and the next copy.
        blank_mode = 1'b1;
        run_until(VT * HT + VA * HT + LEN + 20);
        blank_mode = 1'b0;
        run_until(VT * HT + VA * HT + HT + 50);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_scan.md
# video_scan

Pixel-rate scan controller driving the `gpu` rectangle renderer. Once per frame:
- generates the 640x480@60 raster coordinates, sync and blanking.
- at the start of vertical blank, streams the 384-word rectangle table from video RAM into the `gpu` load port (`we`/`mem_din`).
- takes the `gpu` `color` output, delays it and gates it with blanking, then presents it to the display pins.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch (line total 800)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch (frame total 525)
- `TABLE_BASE`, 16'd0, first video-RAM word of the rectangle table
- `TABLE_LEN`, 384, words copied per frame (64 rects x 6 words)
- `GPU_LATENCY`, 1, cycles from `x_coord`/`y_coord` to valid `gpu_color`

Ports:
- `pixel_clk` in 1: pixel clock
- `reset` in 1: asynchronous, active-high
- `x_coord` out 16: horizontal counter, 0..799
- `y_coord` out 16: vertical counter, 0..524
- `mem_addr` out 16: video-RAM read address
- `mem_rdata` in 16: video-RAM read data, synchronous, 1-cycle latency
- `gpu_we` out 1: `gpu` load strobe
- `gpu_din` out 16: `gpu` load data
- `gpu_idle` out 1: `gpu` idle input
- `gpu_color` in 16: `gpu` pixel colour
- `hsync` out 1: active-low
- `vsync` out 1: active-low
- `de` out 1: display enable
- `rgb` out 16: RGB565 pixel, 0 when `de`=0
- `frame_irq` out 1: one-cycle pulse when the table copy completes

## Operation
- Raster counters:
  - `x_coord` increments every cycle and wraps 799->0.
  - On that wrap `y_coord` increments, wrapping 524->0.
- Raw hsync is low for x in [656,751]; raw vsync is low for y in [490,491]; raw de = (x<640)&&(y<480).
- Copy FSM states: IDLE, READ, DRAIN.
  - IDLE->READ when x==0 and y==V_ACTIVE, i.e. on the first blank line.
  - READ: `mem_addr`=TABLE_BASE+i, with i running 0..TABLE_LEN-1, one word per cycle. After i==TABLE_LEN-1 go to DRAIN.
  - DRAIN: lasts 2 cycles so that the last words flush, then IDLE.
- Data pipeline:
  - `mem_rdata` is registered into `gpu_din`, with `gpu_we` as its valid, 2 cycles after the matching address.
  - Exactly TABLE_LEN `gpu_we` pulses per frame, contiguous, in address order.
- `mem_addr` holds TABLE_BASE outside READ.
- `frame_irq` pulses on the cycle after the last `gpu_we`.
- `gpu_idle`:
  - 1 while y>=V_ACTIVE and the FSM is IDLE (rendering not needed).
  - 0 during active lines and during the copy.
- Output alignment:
  - hsync, vsync and de are delayed GPU_LATENCY cycles, then registered once more together with `rgb`.
  - `rgb` = delayed de ? `gpu_color` : 0.
- Counter and index widths are 16 bits and are compared unsigned. The copy index is 9 bits minimum and must hold TABLE_LEN.

## Timing
- Reset values (asynchronous):
  - x_coord=0, y_coord=0, FSM=IDLE, mem_addr=TABLE_BASE.
  - gpu_we=0, gpu_din=0, gpu_idle=0, frame_irq=0.
  - hsync=1, vsync=1, de=0, rgb=0.
  - All delay-line stages are cleared to the inactive values.
- First `gpu_we` occurs 2 cycles after READ entry, i.e. at x==2 of line 480. The last occurs at x==385; `frame_irq` fires at x==386.
- Display outputs lag the coordinates by GPU_LATENCY+1 cycles, so pixel (0,0) appears on `rgb` at cycle GPU_LATENCY+1 after x=0,y=0.
- Reset mid-copy:
  - The copy aborts immediately, with no further `gpu_we` and no `frame_irq`.
  - The next copy starts only at the next y==480, x==0.
- TABLE_LEN+2 must be <= line total. This is a static check, not handled at run time.
- Copy start and the frame wrap can never coincide; no arbitration is needed.

## Structure
- Shared package `video_pkg`:
  - 640x480 timing constants (H/V active, porch and sync widths, totals).
  - TABLE_LEN and the rect word count (6).
  - Copy FSM state enum.
- Natural sub-module: `sync_delay`, a parameterised shift register (depth, width, reset value) used for the hsync/vsync/de alignment.

## Test plan
- Reset:
  - Assert reset mid-line.
  - Required: all outputs at their reset values within the same cycle.
  - After release, x_coord counts 0,1,2…; y_coord increments at x 799->0 and wraps 524->0.
- Sync:
  - Required: hsync low exactly 96 cycles starting at x=656 (+GPU_LATENCY+1).
  - vsync low for lines 490–491.
  - 800 cycles per line, 420000 per frame.
- Table copy:
  - Preload RAM word k = 16'hA000+k.
  - Required: 384 contiguous `gpu_we` pulses from x=2 of line 480, with `gpu_din` = A000..A17F in order.
  - `frame_irq` fires once, at x=386.
- Blanking:
  - Drive `gpu_color`=16'hFFFF constantly.
  - Required: `rgb`=FFFF only while delayed de=1; 0 otherwise, including pixel 640 and line 480.
- Reset mid-copy:
  - Assert reset when i=100.
  - Required: `gpu_we` drops with no `frame_irq`; the next full 384-word copy occurs at the following y=480.
- Idle:
  - Required: `gpu_idle`=0 at lines 0–479 and during the copy.
  - `gpu_idle`=1 from x=388 of line 480 through line 524.
